// File: rtl/vx_icache_responder.sv
// vx_icache_responder: responder end of the icache fetch handshake.
// Accepts tagged word-address requests, reads an internal instruction
// memory at acceptance, delays the result through a fixed-latency pipe and
// returns it in order through a credit-limited response queue.
module vx_icache_responder #(
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned QUEUE_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         icache_req_valid,
    input  logic [ADDR_WIDTH-1:0]        icache_req_addr,
    input  logic [TAG_WIDTH-1:0]         icache_req_tag,
    output logic                         icache_req_ready,
    output logic                         icache_rsp_valid,
    output logic [8*WORD_SIZE-1:0]       icache_rsp_data,
    output logic [TAG_WIDTH-1:0]         icache_rsp_tag,
    input  logic                         icache_rsp_ready,
    input  logic                         init_valid,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [8*WORD_SIZE-1:0]       init_data,
    output logic                         busy
);

    localparam int unsigned DATA_W  = 8 * WORD_SIZE;
    localparam int unsigned MEM_AW  = $clog2(MEM_WORDS);
    localparam int unsigned QAW     = $clog2(QUEUE_SIZE);
    localparam int unsigned PTR_W   = QAW + 1;
    localparam int unsigned CNT_W   = QAW + 1;
    localparam int unsigned PIPE_DW = LATENCY * DATA_W;
    localparam int unsigned PIPE_TW = LATENCY * TAG_WIDTH;

    // Instruction storage; contents survive reset.
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Request credit enable: low in reset, high from the first edge after release.
    logic ready_en_q, ready_en_d;

    // Outstanding requests: in-flight pipeline entries plus queued entries.
    logic [CNT_W-1:0] count_q, count_d;

    // Fixed-latency read pipeline, stage 0 loaded at acceptance.
    logic [LATENCY-1:0]                 pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0][DATA_W-1:0]     pipe_data_q,  pipe_data_d;
    logic [LATENCY-1:0][TAG_WIDTH-1:0]  pipe_tag_q,   pipe_tag_d;

    // Response queue; pointers carry one extra bit to tell full from empty.
    logic [QUEUE_SIZE-1:0][DATA_W-1:0]    fifo_data_q, fifo_data_d;
    logic [QUEUE_SIZE-1:0][TAG_WIDTH-1:0] fifo_tag_q,  fifo_tag_d;
    logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                     rd_ptr_q, rd_ptr_d;

    logic              accept_c;
    logic              pop_c;
    logic              push_c;
    logic              empty_c;
    logic [MEM_AW-1:0] rd_idx_c;
    logic [DATA_W-1:0] rd_data_c;

    // Upper address bits are ignored so addresses wrap over the memory.
    if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^icache_req_addr[ADDR_WIDTH-1:MEM_AW];
    end

    // Handshake decode and output presentation of the queue head.
    assign rd_idx_c         = icache_req_addr[MEM_AW-1:0];
    assign rd_data_c        = mem[rd_idx_c];
    assign empty_c          = (wr_ptr_q == rd_ptr_q);
    assign icache_req_ready = ready_en_q && (count_q < CNT_W'(QUEUE_SIZE));
    assign accept_c         = icache_req_valid && icache_req_ready;
    assign icache_rsp_valid = !empty_c;
    assign pop_c            = icache_rsp_valid && icache_rsp_ready;
    assign push_c           = pipe_valid_q[LATENCY-1];
    assign icache_rsp_data  = icache_rsp_valid ? fifo_data_q[rd_ptr_q[QAW-1:0]] : '0;
    assign icache_rsp_tag   = icache_rsp_valid ? fifo_tag_q[rd_ptr_q[QAW-1:0]]  : '0;
    assign busy             = (count_q != '0);

    // Program-load write port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (init_valid) begin
            mem[init_addr] <= init_data;
        end
    end

    // Credit enable comes up one edge after reset release.
    always_comb begin
        ready_en_d = 1'b1;
    end

    // Outstanding counter: +1 on accept, -1 on pop, unchanged on both.
    always_comb begin
        count_d = count_q;
        case ({accept_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pipeline always shifts; credits guarantee room in the queue on exit.
    always_comb begin
        pipe_valid_d = LATENCY'({pipe_valid_q, accept_c});
        pipe_data_d  = PIPE_DW'({pipe_data_q, rd_data_c});
        pipe_tag_d   = PIPE_TW'({pipe_tag_q, icache_req_tag});
    end

    // Response queue: push from the last pipe stage, pop on handshake.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_c) begin
            fifo_data_d[wr_ptr_q[QAW-1:0]] = pipe_data_q[LATENCY-1];
            fifo_tag_d[wr_ptr_q[QAW-1:0]]  = pipe_tag_q[LATENCY-1];
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // State registers; reset drops every in-flight and queued response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q   <= 1'b0;
            count_q      <= '0;
            pipe_valid_q <= '0;
            pipe_data_q  <= '0;
            pipe_tag_q   <= '0;
            fifo_data_q  <= '0;
            fifo_tag_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            ready_en_q   <= ready_en_d;
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            pipe_tag_q   <= pipe_tag_d;
            fifo_data_q  <= fifo_data_d;
            fifo_tag_q   <= fifo_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_vx_icache_responder.sv
// Testbench for vx_icache_responder: directed scenarios plus a random phase,
// checked every cycle against a transaction-level reference model.
module tb_vx_icache_responder;

    localparam int unsigned WORD_SIZE  = 4;
    localparam int unsigned ADDR_WIDTH = 30;
    localparam int unsigned TAG_WIDTH  = 4;
    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned QUEUE_SIZE = 4;
    localparam int unsigned DW         = 8 * WORD_SIZE;
    localparam int unsigned MAW        = $clog2(MEM_WORDS);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  icache_req_valid;
    logic [ADDR_WIDTH-1:0] icache_req_addr;
    logic [TAG_WIDTH-1:0]  icache_req_tag;
    logic                  icache_req_ready;
    logic                  icache_rsp_valid;
    logic [DW-1:0]         icache_rsp_data;
    logic [TAG_WIDTH-1:0]  icache_rsp_tag;
    logic                  icache_rsp_ready;
    logic                  init_valid;
    logic [MAW-1:0]        init_addr;
    logic [DW-1:0]         init_data;
    logic                  busy;

    always #5 clk = ~clk;

    vx_icache_responder #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH),
        .TAG_WIDTH (TAG_WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY),
        .QUEUE_SIZE(QUEUE_SIZE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_req_valid(icache_req_valid),
        .icache_req_addr (icache_req_addr),
        .icache_req_tag  (icache_req_tag),
        .icache_req_ready(icache_req_ready),
        .icache_rsp_valid(icache_rsp_valid),
        .icache_rsp_data (icache_rsp_data),
        .icache_rsp_tag  (icache_rsp_tag),
        .icache_rsp_ready(icache_rsp_ready),
        .init_valid      (init_valid),
        .init_addr       (init_addr),
        .init_data       (init_data),
        .busy            (busy)
    );

    // Reference model: a memory image, requests in flight with their due
    // edge, and the responses the requester can currently see (FIFO order).
    typedef struct {
        logic [DW-1:0]        data;
        logic [TAG_WIDTH-1:0] tag;
        int                   due;
    } ent_t;

    ent_t          pend[$];
    ent_t          visq[$];
    logic [DW-1:0] mem_m [MEM_WORDS];
    logic [DW-1:0] popped[$];
    bit            ready_en_m = 1'b0;
    int            edge_n     = 0;
    bit            last_acc;
    bit            last_pop;
    int            n_cmp      = 0;
    int            n_fail     = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        visq.delete();
        ready_en_m = 1'b0;
    endtask

    // One clock cycle: compare outputs, then advance the model across the edge.
    task automatic step();
        bit ready_m;
        int cnt;
        int idx;
        #1;
        cnt     = pend.size() + visq.size();
        ready_m = ready_en_m && (cnt < int'(QUEUE_SIZE));
        check("req_ready", icache_req_ready, ready_m);
        check("busy", busy, cnt != 0);
        check("rsp_valid", icache_rsp_valid, visq.size() != 0);
        if (visq.size() != 0) begin
            check("rsp_data", icache_rsp_data, visq[0].data);
            check("rsp_tag", icache_rsp_tag, visq[0].tag);
        end else begin
            check("rsp_data_idle", icache_rsp_data, 0);
            check("rsp_tag_idle", icache_rsp_tag, 0);
        end
        last_acc = icache_req_valid && ready_m;
        last_pop = (visq.size() != 0) && icache_rsp_ready;
        if (icache_rsp_valid && icache_rsp_ready) popped.push_back(icache_rsp_data);
        idx = int'(icache_req_addr % MEM_WORDS);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            edge_n++;
            if (last_pop) void'(visq.pop_front());
            while (pend.size() != 0 && pend[0].due == edge_n) visq.push_back(pend.pop_front());
            if (last_acc) pend.push_back('{mem_m[idx], icache_req_tag, edge_n + int'(LATENCY)});
            if (init_valid) mem_m[init_addr] = init_data;
            ready_en_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        icache_req_valid = 1'b0;
        icache_rsp_ready = 1'b1;
        for (int k = 0; k < 40 && (pend.size() + visq.size()) != 0; k++) step();
        check("drain_done", pend.size() + visq.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int pop_n;
        reset            = 1'b0;
        icache_req_valid = 1'b0;
        icache_req_addr  = '0;
        icache_req_tag   = '0;
        icache_rsp_ready = 1'b0;
        init_valid       = 1'b0;
        init_addr        = '0;
        init_data        = '0;

        // Reset state
        #2;
        check("rst_req_ready", icache_req_ready, 1'b0);
        check("rst_rsp_valid", icache_rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_data", icache_rsp_data, 0);
        @(negedge clk);
        step();
        step();
        reset = 1'b1;
        step();
        check("ready_after_release", icache_req_ready, 1'b1);

        // Program load: mem[0..7] = 0x1000+i, the rest random
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            init_valid = 1'b1;
            init_addr  = MAW'(i);
            init_data  = (i < 8) ? DW'(32'h1000 + i) : DW'($urandom);
            step();
        end
        init_valid = 1'b0;

        // Test 1: single request, minimum latency
        icache_rsp_ready = 1'b1;
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'd3;
        icache_req_tag   = 4'd5;
        step();
        check("t1_accept", last_acc, 1'b1);
        icache_req_valid = 1'b0;
        check("t1_busy_n1", busy, 1'b1);
        check("t1_valid_n1", icache_rsp_valid, 1'b0);
        step();
        check("t1_valid_n2", icache_rsp_valid, 1'b0);
        step();
        check("t1_valid_n3", icache_rsp_valid, 1'b1);
        check("t1_data", icache_rsp_data, 32'h1003);
        check("t1_tag", icache_rsp_tag, 4'd5);
        step();
        check("t1_busy_after", busy, 1'b0);

        // Test 2: backpressure, credit limit of QUEUE_SIZE
        icache_rsp_ready = 1'b0;
        popped.delete();
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = ADDR_WIDTH'(acc_n);
            icache_req_tag   = TAG_WIDTH'(acc_n);
            step();
            if (last_acc) acc_n++;
        end
        check("t2_accepted", acc_n, 4);
        check("t2_ready_low", icache_req_ready, 1'b0);
        icache_rsp_ready = 1'b1;
        for (int c = 0; c < 40 && (acc_n < 6 || (pend.size() + visq.size()) != 0); c++) begin
            icache_req_valid = (acc_n < 6);
            icache_req_addr  = ADDR_WIDTH'(acc_n);
            icache_req_tag   = TAG_WIDTH'(acc_n);
            step();
            if (last_acc) acc_n++;
        end
        icache_req_valid = 1'b0;
        check("t2_all_accepted", acc_n, 6);
        check("t2_pop_count", popped.size(), 6);
        for (int k = 0; k < 6 && k < popped.size(); k++) begin
            check("t2_order", popped[k], 32'h1000 + k);
        end

        // Test 3: streaming, one accept and one response per cycle
        acc_n = 0;
        pop_n = 0;
        for (int c = 0; c < 16; c++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = ADDR_WIDTH'($urandom_range(0, 7));
            icache_req_tag   = TAG_WIDTH'(c);
            step();
            if (last_acc) acc_n++;
            if (last_pop) pop_n++;
        end
        check("t3_accepts", acc_n, 16);
        check("t3_pops", pop_n, 16 - (LATENCY + 1));
        drain();

        // Test 4: address wrap
        popped.delete();
        icache_req_valid = 1'b1;
        icache_req_addr  = ADDR_WIDTH'(MEM_WORDS + 2);
        icache_req_tag   = 4'd9;
        step();
        drain();
        check("t4_count", popped.size(), 1);
        if (popped.size() != 0) check("t4_wrap_data", popped[0], 32'h1002);

        // Test 5: write and read of the same address in one cycle
        popped.delete();
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'd4;
        icache_req_tag   = 4'd2;
        init_valid       = 1'b1;
        init_addr        = MAW'(4);
        init_data        = 32'hDEAD;
        step();
        init_valid = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_tag   = 4'd3;
        step();
        drain();
        check("t5_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check("t5_old_data", popped[0], 32'h1004);
            check("t5_new_data", popped[1], 32'hDEAD);
        end

        // Test 6: reset with requests outstanding
        icache_rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = ADDR_WIDTH'(c + 5);
            icache_req_tag   = TAG_WIDTH'(c);
            step();
        end
        icache_req_valid = 1'b0;
        step();
        check("t6_busy_before", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_rsp_valid", icache_rsp_valid, 1'b0);
        check("t6_async_req_ready", icache_req_ready, 1'b0);
        check("t6_async_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        step();
        reset = 1'b1;
        popped.delete();
        icache_rsp_ready = 1'b1;
        repeat (6) step();
        check("t6_no_stale", popped.size(), 0);
        icache_req_valid = 1'b1;
        icache_req_addr  = 30'd1;
        icache_req_tag   = 4'd7;
        step();
        drain();
        check("t6_count", popped.size(), 1);
        if (popped.size() != 0) check("t6_data", popped[0], 32'h1001);

        // Random phase
        for (int c = 0; c < 500; c++) begin
            icache_req_valid = ($urandom_range(0, 3) != 0);
            icache_req_addr  = ADDR_WIDTH'($urandom_range(0, 2 * MEM_WORDS - 1));
            icache_req_tag   = TAG_WIDTH'($urandom);
            icache_rsp_ready = ($urandom_range(0, 9) < 7);
            init_valid       = ($urandom_range(0, 9) == 0);
            init_addr        = MAW'($urandom);
            init_data        = DW'($urandom);
            step();
        end
        init_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
